// File: rtl/bs_gnrt.sv
// bs_gnrt: multi-bus packet generator that pops packets from device FIFOs and pushes them to the addressed devices
// Ports:
//   clk     rising-edge system clock
//   reset   synchronous active-high reset
//   pndng   per bus/device: output FIFO non-empty, head valid on D_pop
//   push    per bus/device: one-cycle write strobe into the device input FIFO
//   pop     per bus/device: one-cycle read strobe to the device output FIFO
//   D_pop   per bus/device: head packet of the device output FIFO
//   D_push  per bus/device: captured packet, valid where push=1
module bs_gnrt #(
    parameter int         bits      = 1,
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [bits-1:0][drvrs-1:0]               pndng,
    output logic [bits-1:0][drvrs-1:0]               push,
    output logic [bits-1:0][drvrs-1:0]               pop,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_pop,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_push
);
    localparam int GW = drvrs > 1 ? $clog2(drvrs) : 1;
    typedef enum logic [1:0] {IDLE, POP, PUSH} st_t;
    genvar b;
    generate
        for (b = 0; b < bits; b++) begin : g_bus
            st_t                st;
            logic [GW-1:0]      grant, nxt;
            logic [drvrs-1:0]   sel, tgt, pop_r, push_r;
            logic [pckg_sz-1:0] pkt, head;
            logic [7:0]         dest;
            assign head = D_pop[b][grant];
            assign dest = head[pckg_sz-1 -: 8];
            // descending scan so the smallest offset after the last grant wins
            always_comb begin
                nxt = grant;
                sel = '0;
                tgt = '0;
                for (int i = drvrs; i >= 1; i--)
                    if (pndng[b][(int'(grant) + i) % drvrs]) nxt = GW'((int'(grant) + i) % drvrs);
                for (int j = 0; j < drvrs; j++) begin
                    sel[j] = int'(nxt) == j;
                    tgt[j] = (dest == broadcast) ? (j != int'(grant)) : (int'(dest) == j);
                end
            end
            always_ff @(posedge clk) begin
                if (reset) begin
                    st     <= IDLE;
                    pop_r  <= '0;
                    push_r <= '0;
                    pkt    <= '0;
                    grant  <= GW'(drvrs - 1);
                end else begin
                    case (st)
                        IDLE: begin
                            push_r <= '0;
                            if (|pndng[b]) begin
                                grant <= nxt;
                                pop_r <= sel;
                                st    <= POP;
                            end
                        end
                        POP: begin
                            pop_r  <= '0;
                            pkt    <= head;
                            push_r <= tgt;
                            st     <= PUSH;
                        end
                        PUSH: begin
                            push_r <= '0;
                            st     <= IDLE;
                        end
                        default: st <= IDLE;
                    endcase
                end
            end
            assign pop[b]    = pop_r;
            assign push[b]   = push_r;
            assign D_push[b] = {drvrs{pkt}};
        end
    endgenerate
endmodule

// File: tb/tb_bs_gnrt.sv
// tb_bs_gnrt: randomized bench for bs_gnrt against a transaction-scheduling reference model
module tb_bs_gnrt;
    localparam int B = 2, D = 4, W = 16;
    logic clk = 1'b0, reset = 1'b1;
    logic [B-1:0][D-1:0] pndng, push, pop;
    logic [B-1:0][D-1:0][W-1:0] D_pop, D_push;
    bs_gnrt #(.bits(B), .drvrs(D), .pckg_sz(W), .broadcast(8'hFF)) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .push(push), .pop(pop), .D_pop(D_pop), .D_push(D_push)
    );
    always #5 clk = ~clk;
    int checks = 0, errors = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    typedef struct packed {
        logic [D-1:0] pop;
        logic [D-1:0] push;
        logic [W-1:0] data;
    } out_t;
    logic [W-1:0] q [B][D][$];
    out_t plan [B][$];
    out_t cur [B];
    int last [B];
    int pend [B];
    int grants [$];
    function automatic logic [D-1:0] tgts(input logic [W-1:0] p, input int g);
        logic [D-1:0] t = '0;
        int d = int'(p[W-1 -: 8]);
        if (d == 255) begin
            t = '1;
            t[g] = 1'b0;
        end else if (d < D) t[d] = 1'b1;
        return t;
    endfunction
    task automatic put(input int b, input int d, input logic [W-1:0] p);
        q[b][d].push_back(p);
    endtask
    function automatic logic [W-1:0] rnd_pkt();
        int r = $urandom_range(0, 5);
        logic [7:0] dst = r < 4 ? 8'(r) : r == 4 ? 8'hFF : 8'($urandom_range(4, 254));
        return {dst, 8'($urandom)};
    endfunction
    task automatic step(input logic r);
        int rmv [B];
        reset = r;
        for (int b = 0; b < B; b++)
            for (int j = 0; j < D; j++) begin
                pndng[b][j] = q[b][j].size() != 0;
                D_pop[b][j] = q[b][j].size() != 0 ? q[b][j][0] : W'($urandom);
            end
        for (int b = 0; b < B; b++) begin
            rmv[b] = pend[b];
            pend[b] = -1;
            cur[b].pop = '0;
            cur[b].push = '0;
            if (r) begin
                plan[b].delete();
                cur[b].data = '0;
                last[b] = D - 1;
            end else if (plan[b].size() != 0) cur[b] = plan[b].pop_front();
            else begin
                int g = -1;
                for (int k = 1; k <= D && g < 0; k++)
                    if (q[b][(last[b] + k) % D].size() != 0) g = (last[b] + k) % D;
                if (g >= 0) begin
                    logic [W-1:0] p = q[b][g][0];
                    last[b] = g;
                    pend[b] = g;
                    cur[b].pop[g] = 1'b1;
                    if (b == 0) grants.push_back(g);
                    plan[b].push_back('{pop: '0, push: tgts(p, g), data: p});
                    plan[b].push_back('{pop: '0, push: '0, data: p});
                end
            end
        end
        @(negedge clk);
        for (int b = 0; b < B; b++) begin
            chk($sformatf("pop b%0d", b), 64'(pop[b]), 64'(cur[b].pop));
            chk($sformatf("push b%0d", b), 64'(push[b]), 64'(cur[b].push));
            chk($sformatf("dpush b%0d", b), 64'(D_push[b]), 64'({D{cur[b].data}}));
            if (rmv[b] >= 0) void'(q[b][rmv[b]].pop_front());
        end
    endtask
    task automatic run(input int n);
        repeat (n) step(1'b0);
    endtask
    initial begin
        for (int b = 0; b < B; b++) begin
            last[b] = D - 1;
            pend[b] = -1;
            cur[b] = '0;
        end
        for (int j = 0; j < D; j++) put(0, j, {8'(j), 8'h10 + 8'(j)});
        step(1'b1);
        step(1'b1);
        run(14);
        chk("order", {grants[0], grants[1], grants[2], grants[3]}, {32'd0, 32'd1, 32'd2, 32'd3});
        put(0, 1, 16'h02AB);
        run(4);
        chk("t2 grant", 64'(grants[4]), 64'd1);
        put(0, 3, 16'hFF5A);
        run(4);
        for (int j = 0; j < D; j++) put(0, j, 16'h0100 | 16'(j));
        for (int j = 0; j < D; j++) put(0, j, 16'h0200 | 16'(j));
        run(30);
        put(0, 0, 16'h0711);
        put(0, 2, 16'h0233);
        run(8);
        put(0, 2, 16'h0144);
        put(0, 1, 16'h0055);
        begin
            int n = 0;
            while (cur[0].pop == '0 && n < 20) begin
                step(1'b0);
                n++;
            end
            chk("pop seen", 64'(cur[0].pop != '0), 64'd1);
        end
        step(1'b1);
        for (int j = 0; j < D; j++) put(0, j, 16'h0300 | 16'(j));
        run(40);
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < B; b++)
                if ($urandom_range(0, 3) == 0) begin
                    int d = $urandom_range(0, D - 1);
                    if (q[b][d].size() < 4) put(b, d, rnd_pkt());
                end
            step($urandom_range(0, 199) == 0);
        end
        run(60);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
